// File: rtl/snn_pkg.sv
// Shared types, constants and winner selection for the spike window readout.
package snn_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } state_t;

  localparam int MAX_CH = 32;
  localparam int MAX_W  = 32;

  // Wide all-ones patterns; users slice them down to their own widths.
  localparam logic [MAX_W-1:0] CNT_MAX  = '1;
  localparam logic [MAX_W-1:0] NO_SPIKE = '1;

  // Argmax over the first n counts; strict '>' keeps the lowest index on ties.
  function automatic int pick_winner(input logic [MAX_CH-1:0][MAX_W-1:0] counts,
                                     input int n);
    int best_idx;
    logic [MAX_W-1:0] best;
    best_idx = 0;
    best = counts[0];
    for (int i = 1; i < MAX_CH; i++) begin
      if (i < n && counts[i] > best) begin
        best = counts[i];
        best_idx = i;
      end
    end
    return best_idx;
  endfunction

endpackage

// File: rtl/spike_window_ch.sv
// One readout channel: saturating spike counter, saturation flag and, with
// SPIKE_WINDOW_TTFS_EN, the index of the first spike in the window.
module spike_window_ch
  import snn_pkg::*;
#(
  parameter int CNT_W = 8,
  parameter int WIN_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             spike,
  input  logic             clear,
  input  logic [WIN_W-1:0] idx,
  output logic [CNT_W-1:0] count_next,
  output logic             sat_next
`ifdef SPIKE_WINDOW_TTFS_EN
  , output logic [WIN_W-1:0] ttfs_next
`endif
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_MAX[CNT_W-1:0];

  logic [CNT_W-1:0] count_q;
  logic             sat_q;

  // Next values include this cycle's spike so the top can capture them on the last edge.
  always_comb begin
    count_next = count_q;
    sat_next   = sat_q;
    if (spike && count_q != MAX_CNT) count_next = count_q + CNT_W'(1);
    if (count_next == MAX_CNT) sat_next = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      sat_q   <= 1'b0;
    end else if (clear) begin
      count_q <= '0;
      sat_q   <= 1'b0;
    end else begin
      count_q <= count_next;
      sat_q   <= sat_next;
    end
  end

`ifdef SPIKE_WINDOW_TTFS_EN
  localparam logic [WIN_W-1:0] NONE = NO_SPIKE[WIN_W-1:0];

  logic [WIN_W-1:0] ttfs_q;

  assign ttfs_next = (spike && ttfs_q == NONE) ? idx : ttfs_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        ttfs_q <= NONE;
    else if (clear) ttfs_q <= NONE;
    else            ttfs_q <= ttfs_next;
  end
`else
  logic idx_unused;
  assign idx_unused = ^idx;
`endif

endmodule

// File: rtl/spike_window_decoder.sv
// Windowed spike counter readout with argmax winner and valid/ready result.
// Optional first-spike times are enabled with SPIKE_WINDOW_TTFS_EN.
module spike_window_decoder
  import snn_pkg::*;
#(
  parameter int CHANNELS = 8,
  parameter int CNT_W    = 8,
  parameter int WIN_W    = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         enable,
  input  logic [WIN_W-1:0]             window_len,
  input  logic [CHANNELS-1:0]          spike_in,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [CHANNELS*CNT_W-1:0]    out_counts,
  output logic [CHANNELS-1:0]          out_sat,
  output logic [$clog2(CHANNELS)-1:0]  out_winner,
  output logic                         overrun
`ifdef SPIKE_WINDOW_TTFS_EN
  , output logic [CHANNELS*WIN_W-1:0]  out_ttfs
`endif
);

  localparam int IDX_W = $clog2(CHANNELS);

  state_t                       state;
  logic [WIN_W-1:0]             idx;
  logic [WIN_W-1:0]             len_q;
  logic [WIN_W-1:0]             len_eff;
  logic [CHANNELS*CNT_W-1:0]    cnt_nxt;
  logic [CHANNELS-1:0]          sat_nxt;
  logic                         last;
  logic                         load;
  logic                         clear_ch;
  logic                         xfer;
  logic [MAX_CH-1:0][MAX_W-1:0] cnt_vec;
  int                           win_idx;
`ifdef SPIKE_WINDOW_TTFS_EN
  logic [CHANNELS*WIN_W-1:0]    ttfs_nxt;
`endif

  assign len_eff  = (window_len == '0) ? WIN_W'(1) : window_len;
  assign last     = (state == COUNT) && (idx == len_q - WIN_W'(1));
  assign load     = last && enable;
  // Counters restart on the last edge so the next window has no gap cycle.
  assign clear_ch = (state != COUNT) || !enable || last;
  assign xfer     = out_valid && out_ready;

  always_comb begin
    cnt_vec = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      cnt_vec[i] = MAX_W'(cnt_nxt[i*CNT_W +: CNT_W]);
    end
    win_idx = pick_winner(cnt_vec, CHANNELS);
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    spike_window_ch #(
      .CNT_W (CNT_W),
      .WIN_W (WIN_W)
    ) u_ch (
      .clk        (clk),
      .rst        (rst),
      .spike      (spike_in[i]),
      .clear      (clear_ch),
      .idx        (idx),
      .count_next (cnt_nxt[i*CNT_W +: CNT_W]),
      .sat_next   (sat_nxt[i])
`ifdef SPIKE_WINDOW_TTFS_EN
      , .ttfs_next (ttfs_nxt[i*WIN_W +: WIN_W])
`endif
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      idx        <= '0;
      len_q      <= WIN_W'(1);
      out_valid  <= 1'b0;
      out_counts <= '0;
      out_sat    <= '0;
      out_winner <= '0;
      overrun    <= 1'b0;
`ifdef SPIKE_WINDOW_TTFS_EN
      out_ttfs   <= '1;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (enable) begin
            state <= COUNT;
            idx   <= '0;
            len_q <= len_eff;
          end
        end
        COUNT: begin
          if (!enable) begin
            state <= IDLE;
            idx   <= '0;
          end else if (last) begin
            idx   <= '0;
            len_q <= len_eff;
          end else begin
            idx <= idx + WIN_W'(1);
          end
        end
        default: state <= IDLE;
      endcase

      // A held, unaccepted result wins over a new one; the new one is lost.
      if (load && (!out_valid || out_ready)) begin
        out_valid  <= 1'b1;
        out_counts <= cnt_nxt;
        out_sat    <= sat_nxt;
        out_winner <= IDX_W'(win_idx);
`ifdef SPIKE_WINDOW_TTFS_EN
        out_ttfs   <= ttfs_nxt;
`endif
      end else begin
        if (load) overrun <= 1'b1;
        if (xfer) out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_spike_window_decoder.sv
// Directed bench for spike_window_decoder; a second CNT_W=4 instance covers saturation.
module tb_spike_window_decoder;

  logic        clk;
  logic        rst;
  logic        enable;
  logic [7:0]  window_len;
  logic [7:0]  spike_in;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_counts;
  logic [7:0]  out_sat;
  logic [2:0]  out_winner;
  logic        overrun;

  logic        s_enable;
  logic [7:0]  s_len;
  logic [7:0]  s_spike;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] s_counts;
  logic [7:0]  s_sat;
  logic [2:0]  s_winner;
  logic        s_overrun;

`ifdef SPIKE_WINDOW_TTFS_EN
  logic [63:0] out_ttfs;
  logic [63:0] s_ttfs;
`endif

  int checks = 0;
  int errors = 0;

  spike_window_decoder u_dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .window_len (window_len),
    .spike_in   (spike_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_counts (out_counts),
    .out_sat    (out_sat),
    .out_winner (out_winner),
    .overrun    (overrun)
`ifdef SPIKE_WINDOW_TTFS_EN
    , .out_ttfs (out_ttfs)
`endif
  );

  spike_window_decoder #(.CHANNELS(8), .CNT_W(4), .WIN_W(8)) u_sat (
    .clk        (clk),
    .rst        (rst),
    .enable     (s_enable),
    .window_len (s_len),
    .spike_in   (s_spike),
    .out_valid  (s_valid),
    .out_ready  (s_ready),
    .out_counts (s_counts),
    .out_sat    (s_sat),
    .out_winner (s_winner),
    .overrun    (s_overrun)
`ifdef SPIKE_WINDOW_TTFS_EN
    , .out_ttfs (s_ttfs)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach its end");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] cnt8(input logic [63:0] v, input int ch);
    return v[ch*8 +: 8];
  endfunction

  initial begin
    rst = 1'b1;
    enable = 1'b0;
    window_len = 8'd10;
    spike_in = '0;
    out_ready = 1'b1;
    s_enable = 1'b0;
    s_len = 8'd20;
    s_spike = '0;
    s_ready = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", {63'd0, out_valid}, 64'd0);
    check("rst_counts", out_counts, 64'd0);
    check("rst_sat", {56'd0, out_sat}, 64'd0);
    check("rst_winner", {61'd0, out_winner}, 64'd0);
    check("rst_overrun", {63'd0, overrun}, 64'd0);
`ifdef SPIKE_WINDOW_TTFS_EN
    check("rst_ttfs", out_ttfs, 64'hFFFF_FFFF_FFFF_FFFF);
`endif
    rst = 1'b0;
    tick();

    // Window 1: ch3 every cycle, ch0 on even indices, L=10
    enable = 1'b1;
    tick();
    for (int i = 0; i < 10; i++) begin
      spike_in = (i % 2 == 0) ? 8'h09 : 8'h08;
      if (i == 9) check("w1_not_early", {63'd0, out_valid}, 64'd0);
      tick();
    end
    check("w1_valid", {63'd0, out_valid}, 64'd1);
    check("w1_cnt3", {56'd0, cnt8(out_counts, 3)}, 64'd10);
    check("w1_cnt0", {56'd0, cnt8(out_counts, 0)}, 64'd5);
    check("w1_counts", out_counts, 64'h0000_0000_0A00_0005);
    check("w1_winner", {61'd0, out_winner}, 64'd3);
    check("w1_sat", {56'd0, out_sat}, 64'd0);

    // Window 2 starts with no gap: one empty sample, then 9 spikes on ch1
    spike_in = 8'h00;
    tick();
    check("w1_valid_drop", {63'd0, out_valid}, 64'd0);
    spike_in = 8'h02;
    repeat (8) tick();
    check("w2_not_early", {63'd0, out_valid}, 64'd0);
    tick();
    check("w2_valid", {63'd0, out_valid}, 64'd1);
    check("w2_counts", out_counts, 64'h0000_0000_0000_0900);
    check("w2_winner", {61'd0, out_winner}, 64'd1);

    // Window 3: tie between ch2 and ch6
    spike_in = 8'h44;
    repeat (7) tick();
    spike_in = 8'h00;
    repeat (3) tick();
    check("tie_valid", {63'd0, out_valid}, 64'd1);
    check("tie_counts", out_counts, 64'h0007_0000_0007_0000);
    check("tie_winner", {61'd0, out_winner}, 64'd2);
    check("tie_overrun", {63'd0, overrun}, 64'd0);

    // Window 4: empty
    repeat (10) tick();
    check("zero_valid", {63'd0, out_valid}, 64'd1);
    check("zero_counts", out_counts, 64'd0);
    check("zero_winner", {61'd0, out_winner}, 64'd0);

    // Abort at index 5, then restart with L=4
    spike_in = 8'h80;
    repeat (5) tick();
    enable = 1'b0;
    tick();
    check("abort_valid", {63'd0, out_valid}, 64'd0);
    repeat (3) tick();
    check("abort_idle_valid", {63'd0, out_valid}, 64'd0);
    window_len = 8'd4;
    enable = 1'b1;
    tick();
    repeat (4) tick();
    check("restart_valid", {63'd0, out_valid}, 64'd1);
    check("restart_counts", out_counts, 64'h0400_0000_0000_0000);
    check("restart_winner", {61'd0, out_winner}, 64'd7);

    // Back-pressure: result held for 10 cycles while windows overrun
    out_ready = 1'b0;
    spike_in = 8'h01;
    repeat (10) tick();
    check("bp_valid", {63'd0, out_valid}, 64'd1);
    check("bp_counts_held", out_counts, 64'h0400_0000_0000_0000);
    check("bp_winner_held", {61'd0, out_winner}, 64'd7);
    check("bp_overrun", {63'd0, overrun}, 64'd1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp_pulse_drop", {63'd0, out_valid}, 64'd0);
    tick();
    check("bp_next_valid", {63'd0, out_valid}, 64'd1);
    check("bp_next_counts", out_counts, 64'h0000_0000_0000_0004);
    check("bp_next_winner", {61'd0, out_winner}, 64'd0);
    check("bp_overrun_sticky", {63'd0, overrun}, 64'd1);

    // window_len=0 is latched as 1 at the end of the current L=4 window
    out_ready = 1'b1;
    spike_in = 8'h20;
    window_len = 8'd0;
    repeat (4) tick();
    check("l4_counts", out_counts, 64'h0000_0400_0000_0000);
    spike_in = 8'h40;
    tick();
    check("l1_valid", {63'd0, out_valid}, 64'd1);
    check("l1_counts", out_counts, 64'h0001_0000_0000_0000);
    check("l1_winner", {61'd0, out_winner}, 64'd6);
    spike_in = 8'h44;
    tick();
    check("l1b_counts", out_counts, 64'h0001_0000_0001_0000);
    check("l1b_winner", {61'd0, out_winner}, 64'd2);

    // Asynchronous reset mid-window, away from any clock edge
    #2;
    rst = 1'b1;
    enable = 1'b0;
    #1;
    check("arst_valid", {63'd0, out_valid}, 64'd0);
    check("arst_counts", out_counts, 64'd0);
    check("arst_winner", {61'd0, out_winner}, 64'd0);
    check("arst_overrun", {63'd0, overrun}, 64'd0);
    check("arst_sat", {56'd0, out_sat}, 64'd0);
    tick();
    rst = 1'b0;
    spike_in = 8'h00;
    tick();

    // Saturation on the CNT_W=4 instance
    s_enable = 1'b1;
    s_spike = 8'h20;
    tick();
    repeat (20) tick();
    check("sat_valid", {63'd0, s_valid}, 64'd1);
    check("sat_cnt5", {60'd0, s_counts[20 +: 4]}, 64'd15);
    check("sat_flags", {56'd0, s_sat}, 64'h20);
    check("sat_winner", {61'd0, s_winner}, 64'd5);
    s_enable = 1'b0;

`ifdef SPIKE_WINDOW_TTFS_EN
    window_len = 8'd8;
    out_ready = 1'b1;
    enable = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) begin
      spike_in = (i == 3 || i == 5) ? 8'h02 : 8'h00;
      tick();
    end
    check("ttfs_valid", {63'd0, out_valid}, 64'd1);
    check("ttfs_ch1", {56'd0, out_ttfs[8 +: 8]}, 64'd3);
    check("ttfs_ch4", {56'd0, out_ttfs[32 +: 8]}, 64'd255);
    check("ttfs_cnt1", {56'd0, cnt8(out_counts, 1)}, 64'd2);
    enable = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
